hash_scheduler: RTL

- Dispatches whole AXI-Stream messages from a single host stream to one of NUM_ENGINES padder/SHA engines.
- Selects a free engine by round-robin, asserts that engine's en and sha_type, and routes beats to it until tlast.
- Holds the engine busy until it reports its digest done.
- Sits between the host DMA stream and the engine array.

---
 rtl/hash_scheduler.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hash_scheduler.sv
// Dispatches whole AXI-Stream messages to one of NUM_ENGINES hash engines,
// picking a free engine round-robin and holding it busy until it reports done.
module hash_scheduler #(
   parameter int NUM_ENGINES         = 4,
   parameter int P_S_AXIS_DATA_WIDTH = 512,
   parameter int ID_WIDTH            = (NUM_ENGINES > 2) ? $clog2(NUM_ENGINES) : 1
) (
   input  logic                               axi_aclk,
   input  logic                               axi_reset,
   input  logic [P_S_AXIS_DATA_WIDTH-1:0]     s_axis_tdata,
   input  logic [P_S_AXIS_DATA_WIDTH/8-1:0]   s_axis_tkeep,
   input  logic                               s_axis_tuser,
   input  logic                               s_axis_tvalid,
   output logic                               s_axis_tready,
   input  logic                               s_axis_tlast,
   output logic [P_S_AXIS_DATA_WIDTH-1:0]     m_axis_tdata,
   output logic [P_S_AXIS_DATA_WIDTH/8-1:0]   m_axis_tkeep,
   output logic                               m_axis_tlast,
   output logic [NUM_ENGINES-1:0]             m_axis_tvalid,
   input  logic [NUM_ENGINES-1:0]             m_axis_tready,
   output logic [NUM_ENGINES-1:0]             eng_en,
   output logic [NUM_ENGINES-1:0]             eng_sha_type,
   input  logic [NUM_ENGINES-1:0]             eng_done,
   output logic [ID_WIDTH-1:0]                sel_id,
   output logic [NUM_ENGINES-1:0]             busy_map,
   output logic [31:0]                        msg_count
);

   typedef enum logic [1:0] {IDLE, GRANT, STREAM} state_t;

   localparam logic [ID_WIDTH:0] NE = (ID_WIDTH+1)'(NUM_ENGINES);

   state_t                 state, state_nxt;
   logic [ID_WIDTH-1:0]    rr_ptr;
   logic [ID_WIDTH-1:0]    pick;
   logic                   pick_ok;
   logic                   grant;
   logic                   owned;
   logic                   beat_ok;
   logic                   last_ok;
   logic                   done_held;
   logic [NUM_ENGINES-1:0] sel_oh;
   logic [NUM_ENGINES-1:0] done_mask;
   logic [NUM_ENGINES-1:0] busy_nxt;

   assign m_axis_tdata  = s_axis_tdata;
   assign m_axis_tkeep  = s_axis_tkeep;
   assign m_axis_tlast  = s_axis_tlast;
   assign eng_en        = busy_map;

   assign sel_oh        = NUM_ENGINES'(1) << sel_id;
   assign owned         = (state != IDLE);
   assign s_axis_tready = (state == STREAM) && m_axis_tready[sel_id];
   assign m_axis_tvalid = ((state == STREAM) && s_axis_tvalid) ? sel_oh : '0;
   assign beat_ok       = s_axis_tready && s_axis_tvalid;
   assign last_ok       = beat_ok && s_axis_tlast;
   assign grant         = (state == IDLE) && s_axis_tvalid && pick_ok;

   // First free engine at or after rr_ptr; scanning from the far end lets
   // the nearest candidate overwrite the others.
   always_comb begin
      logic [ID_WIDTH:0] sum;
      pick    = '0;
      pick_ok = 1'b0;
      sum     = '0;
      for (int k = NUM_ENGINES - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(k);
         if (sum >= NE) sum = sum - NE;
         if (!busy_map[sum[ID_WIDTH-1:0]]) begin
            pick    = sum[ID_WIDTH-1:0];
            pick_ok = 1'b1;
         end
      end
   end

   // A done from the engine we are still feeding is deferred to its tlast.
   always_comb begin
      done_mask = '0;
      for (int i = 0; i < NUM_ENGINES; i++)
         done_mask[i] = eng_done[i] && busy_map[i] && !(owned && sel_id == ID_WIDTH'(i));
      busy_nxt = busy_map & ~done_mask;
      if (last_ok && (done_held || eng_done[sel_id])) busy_nxt[sel_id] = 1'b0;
      if (grant) busy_nxt[pick] = 1'b1;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (grant)   state_nxt = GRANT;
         GRANT:                state_nxt = STREAM;
         STREAM:  if (last_ok) state_nxt = IDLE;
         default:              state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) state <= IDLE;
      else           state <= state_nxt;
   end

   always_ff @(posedge axi_aclk) begin
      if (axi_reset) begin
         sel_id       <= '0;
         rr_ptr       <= '0;
         busy_map     <= '0;
         eng_sha_type <= '0;
         msg_count    <= '0;
         done_held    <= 1'b0;
      end else begin
         busy_map <= busy_nxt;
         if (grant) begin
            sel_id             <= pick;
            eng_sha_type[pick] <= s_axis_tuser;
            rr_ptr             <= (pick == ID_WIDTH'(NUM_ENGINES - 1)) ? '0 : pick + 1'b1;
            done_held          <= 1'b0;
         end else if (last_ok) begin
            done_held <= 1'b0;
         end else if (owned && eng_done[sel_id]) begin
            done_held <= 1'b1;
         end
         if (last_ok) msg_count <= msg_count + 32'd1;
      end
   end

endmodule
